ram_fill_scan: RTL and testbench
================================

RAM_FILL_SCAN -- requirements
Module: ram_fill_scan

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes SHALL occur on the rising edge of clock.
REQ-002 clock  input  1  system clock, shared with the downstream ram32x4 clock pin.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 mode  input  1  0 = fill, 1 = scan; sampled with start.
REQ-006 fill_data  input  4  fill value; latched when start is accepted.
REQ-007 ram_address  output  5  drives ram32x4 address.
REQ-008 ram_data  output  4  drives ram32x4 data.
REQ-009 ram_wren  output  1  drives ram32x4 wren.
REQ-010 ram_q  input  4  ram32x4 q; equals mem[address captured at the previous edge].
REQ-011 busy  output  1  high in FILL, SCAN and DRAIN.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 checksum  output  9  unsigned sum of the 32 nibbles from the last scan.
REQ-014 max_value  output  4  largest nibble from the last scan.
REQ-015 max_addr  output  5  address of max_value, taking the lowest address on ties.

Function
REQ-016 The states SHALL be IDLE, FILL, SCAN, DRAIN and DONE.
REQ-017 In IDLE with start=1, the next edge SHALL enter FILL (mode=0) or SCAN (mode=1), latch fill_data, and set the address counter to 0.
REQ-018 In IDLE with start=0, the state SHALL remain IDLE.
REQ-019 start SHALL be ignored in all states other than IDLE.
REQ-020 In FILL, ram_wren=1 and ram_data=latched fill value; ram_address=counter; each edge writes one word and increments the counter.
REQ-021 FILL SHALL last exactly 32 cycles (addresses 0..31); the edge that writes address 31 SHALL enter DONE.
REQ-022 In SCAN, ram_wren=0 and ram_address=counter, incrementing 0..31 with one address per cycle; after the edge presenting address 31 the block SHALL enter DRAIN.
REQ-023 Read latency SHALL be one cycle: the ram_q sampled at edge n+1 belongs to the address presented at edge n.
REQ-024 A registered rd_valid flag SHALL qualify sampling; accumulation SHALL occur on the 31 SCAN edges after the first and on the DRAIN edge, giving exactly 32 samples.
REQ-025 On scan start acceptance, checksum SHALL clear to 0.
REQ-026 Each sample SHALL add to checksum zero-extended to 9 bits, with no overflow possible (maximum 480).
REQ-027 max_value and max_addr SHALL load unconditionally on the first sample.
REQ-028 After the first sample, max_value and max_addr SHALL update only when ram_q > max_value (strict comparison).
REQ-029 DRAIN SHALL last exactly 1 cycle, with ram_wren=0, and SHALL then enter DONE.
REQ-030 DONE SHALL last 1 cycle, with done=1 and busy=0, and the next edge SHALL enter IDLE.
REQ-031 Latency SHALL be 33 cycles for fill and 34 cycles for scan, measured from the start-accept edge to the first cycle of done.
REQ-032 ram_wren SHALL be 0 outside FILL.
REQ-033 ram_address SHALL hold its last value in IDLE and DONE.
REQ-034 The 5-bit address counter SHALL wrap from 31 to 0 without affecting the state sequence.
REQ-035 checksum, max_value and max_addr SHALL hold until the next scan start; a fill SHALL NOT alter them.
REQ-036 If start is held high, a new operation SHALL be accepted on the IDLE cycle following DONE.

Reset
REQ-037 With reset=1 at an edge, the next state SHALL be IDLE regardless of the current state, with higher priority than start.
REQ-038 After reset, ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0, checksum=0, max_value=0, max_addr=0, and rd_valid=0.
REQ-039 Reset mid-FILL SHALL stop writes from the next cycle; words already written SHALL remain in the RAM and SHALL NOT be rolled back.
REQ-040 Reset mid-SCAN SHALL discard partial results and SHALL NOT assert done.

Verification
REQ-041 Fill then scan: fill with fill_data=4'hA, then scan -> done 33 and 34 cycles after each accept edge; checksum=320, max_value=A, max_addr=0.
REQ-042 Pattern scan: preload mem[i]=i mod 16 -> checksum=240, max_value=F, max_addr=15 (first F only; the second F at address 31 is ignored).
REQ-043 Busy-start: pulse start with mode=1 during FILL at cycle 10 -> ignored; exactly one done, and a 33-cycle fill completes.
REQ-044 Reset mid-fill: fill_data=5 over RAM all 0, assert reset at FILL cycle 8 -> wren=0 next cycle; a later scan gives checksum=40 (addresses 0..7 hold 5).
REQ-045 Back-to-back scans with start held high, RAM all F -> two done pulses 35 cycles apart; checksum=480 both times, max_addr=0.

Source files
------------

// File: rtl/ram_fill_scan.sv
// ram_fill_scan: fills a 32x4 RAM with one nibble or scans it for
// checksum and first-maximum.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start, mode, fill_data  : request (mode 0 fill / 1 scan), fill value
//   ram_address, ram_data,
//   ram_wren, ram_q         : ram32x4 port (q is one cycle behind address)
//   busy, done              : activity flag, one-cycle completion pulse
//   checksum, max_value,
//   max_addr                : results of the most recent scan
module ram_fill_scan (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] fill_data,
  output logic [4:0] ram_address,
  output logic [3:0] ram_data,
  output logic       ram_wren,
  input  logic [3:0] ram_q,
  output logic       busy,
  output logic       done,
  output logic [8:0] checksum,
  output logic [3:0] max_value,
  output logic [4:0] max_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] addr_cnt;
  logic [3:0] fill_val;
  logic       rd_valid;
  logic [4:0] rd_addr;
  logic       first_smp;

  logic accept;
  logic last_addr;
  logic walking;

  assign accept    = (state == S_IDLE) && start;
  assign last_addr = (addr_cnt == 5'd31);
  assign walking   = (state == S_FILL) || (state == S_SCAN);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (start)
          state_nxt = mode ? S_SCAN : S_FILL;
      end
      (state == S_FILL): begin
        if (last_addr)
          state_nxt = S_DONE;
      end
      (state == S_SCAN): begin
        if (last_addr)
          state_nxt = S_DRAIN;
      end
      (state == S_DRAIN): state_nxt = S_DONE;
      (state == S_DONE):  state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Address counter wraps 31->0 naturally; the FSM alone decides
  // when the walk is over, and the counter holds outside FILL/SCAN.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_cnt <= 5'd0;
      fill_val <= 4'd0;
    end else if (accept) begin
      addr_cnt <= 5'd0;
      fill_val <= fill_data;
    end else if (walking) begin
      addr_cnt <= addr_cnt + 5'd1;
    end
  end

  // The RAM returns data one cycle after the address edge, so the
  // address and a valid flag are delayed by one cycle to line up
  // with ram_q. The DRAIN cycle catches the sample for address 31.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_addr  <= 5'd0;
    end else begin
      rd_valid <= (state == S_SCAN);
      rd_addr  <= addr_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      checksum  <= 9'd0;
      max_value <= 4'd0;
      max_addr  <= 5'd0;
      first_smp <= 1'b0;
    end else if (accept && mode) begin
      checksum  <= 9'd0;
      first_smp <= 1'b1;
    end else if (rd_valid) begin
      checksum  <= checksum + {5'd0, ram_q};
      first_smp <= 1'b0;
      // Strict compare keeps the lowest address on ties.
      if (first_smp || (ram_q > max_value)) begin
        max_value <= ram_q;
        max_addr  <= rd_addr;
      end
    end
  end

  assign ram_address = addr_cnt;
  assign ram_data    = fill_val;
  assign ram_wren    = (state == S_FILL);
  assign busy        = walking || (state == S_DRAIN);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_ram_fill_scan.sv
// tb_ram_fill_scan: scenario bench for ram_fill_scan with a
// behavioural ram32x4 and a whole-array reference model.
module tb_ram_fill_scan;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic [3:0] fill_data;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;
  logic       busy;
  logic       done;
  logic [8:0] checksum;
  logic [3:0] max_value;
  logic [4:0] max_addr;

  int errors;
  int checks;

  logic [3:0] mem [32];
  logic [3:0] ref_mem [32];
  logic [4:0] addr_q;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [3:0] ld_data;

  ram_fill_scan dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .fill_data   (fill_data),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .max_value   (max_value),
    .max_addr    (max_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (ram_wren)
      mem[ram_address] <= ram_data;
    addr_q <= ram_address;
  end

  assign ram_q = mem[addr_q];

  function automatic int ref_sum();
    int s;
    s = 0;
    for (int i = 0; i < 32; i++)
      s += int'(ref_mem[i]);
    return s;
  endfunction

  function automatic int ref_max();
    int m;
    m = 0;
    for (int i = 0; i < 32; i++)
      if (int'(ref_mem[i]) > m)
        m = int'(ref_mem[i]);
    return m;
  endfunction

  function automatic int ref_max_addr();
    int m;
    m = ref_max();
    for (int i = 0; i < 32; i++)
      if (int'(ref_mem[i]) == m)
        return i;
    return 0;
  endfunction

  function automatic int mem_diffs();
    int d;
    d = 0;
    for (int i = 0; i < 32; i++)
      if (mem[i] !== ref_mem[i])
        d++;
    return d;
  endfunction

  task automatic load_ram();
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      ld_en   = 1'b1;
      ld_addr = 5'(i);
      ld_data = ref_mem[i];
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while ((busy || done) && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  // lat counts edges from the accept edge (1) to the edge whose
  // following cycle shows done; 0 means done never came.
  task automatic run_op(input logic m, input logic [3:0] d,
                        output int lat, output int wr, output int bz);
    wait_idle();
    start     = 1'b1;
    mode      = m;
    fill_data = d;
    lat = 0;
    wr  = 0;
    bz  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (k == 1)
        start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (ram_wren) wr++;
      if (busy) bz++;
    end
    start = 1'b0;
  endtask

  task automatic check_scan(input string tag, input int lat);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL %s_lat got=%0d exp=34", tag, lat);
    end
    checks++;
    if (checksum !== 9'(ref_sum())) begin
      errors++;
      $display("FAIL %s_sum got=%0d exp=%0d", tag, checksum, ref_sum());
    end
    checks++;
    if (max_value !== 4'(ref_max())) begin
      errors++;
      $display("FAIL %s_max got=%0d exp=%0d", tag, max_value, ref_max());
    end
    checks++;
    if (max_addr !== 5'(ref_max_addr())) begin
      errors++;
      $display("FAIL %s_maddr got=%0d exp=%0d", tag, max_addr,
               ref_max_addr());
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    reset = 1'b0;
    checks++;
    if ({busy, done, ram_wren} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=000", {busy, done, ram_wren});
    end
    checks++;
    if ({ram_address, ram_data} !== 9'd0) begin
      errors++;
      $display("FAIL reset_port got=%h exp=0", {ram_address, ram_data});
    end
    checks++;
    if ({checksum, max_value, max_addr} !== 18'd0) begin
      errors++;
      $display("FAIL reset_res got=%h exp=0",
               {checksum, max_value, max_addr});
    end
  endtask

  task automatic test_fill_scan();
    int lat, wr, bz;
    run_op(1'b0, 4'hA, lat, wr, bz);
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'hA;
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL fill_lat got=%0d exp=33", lat);
    end
    checks++;
    if (wr !== 32 || bz !== 32) begin
      errors++;
      $display("FAIL fill_wren got=%0d/%0d exp=32/32", wr, bz);
    end
    checks++;
    if (mem_diffs() !== 0) begin
      errors++;
      $display("FAIL fill_mem got=%0d exp=0 diffs", mem_diffs());
    end
    run_op(1'b1, 4'h3, lat, wr, bz);
    check_scan("fs", lat);
    checks++;
    if (wr !== 0 || bz !== 33) begin
      errors++;
      $display("FAIL scan_wren got=%0d/%0d exp=0/33", wr, bz);
    end
  endtask

  task automatic test_pattern();
    int lat, wr, bz;
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'(i % 16);
    load_ram();
    run_op(1'b1, 4'h0, lat, wr, bz);
    check_scan("pat", lat);
  endtask

  task automatic test_busy_start();
    int ndone, first;
    wait_idle();
    start     = 1'b1;
    mode      = 1'b0;
    fill_data = 4'h3;
    ndone = 0;
    first = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) start = 1'b0;
      if (k == 10) begin
        start = 1'b1;
        mode  = 1'b1;
      end
      if (k == 11) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = k;
      end
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h3;
    checks++;
    if (ndone !== 1 || first !== 33) begin
      errors++;
      $display("FAIL busy_start got=%0d@%0d exp=1@33", ndone, first);
    end
    checks++;
    if (mem_diffs() !== 0) begin
      errors++;
      $display("FAIL busy_mem got=%0d exp=0 diffs", mem_diffs());
    end
  endtask

  task automatic test_reset_fill();
    int lat, wr, bz;
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
    load_ram();
    wait_idle();
    start     = 1'b1;
    mode      = 1'b0;
    fill_data = 4'h5;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) start = 1'b0;
    end
    checks++;
    if (ram_address !== 5'd7 || ram_wren !== 1'b1) begin
      errors++;
      $display("FAIL rf_pre got=%0d/%b exp=7/1", ram_address, ram_wren);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rf_stop got=%b/%b exp=0/0", ram_wren, busy);
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = 4'h5;
    checks++;
    if (mem_diffs() !== 0) begin
      errors++;
      $display("FAIL rf_mem got=%0d exp=0 diffs", mem_diffs());
    end
    run_op(1'b1, 4'h9, lat, wr, bz);
    check_scan("rf", lat);
  endtask

  task automatic test_reset_scan();
    int seen;
    wait_idle();
    start     = 1'b1;
    mode      = 1'b1;
    fill_data = 4'h6;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if ({checksum, max_value, max_addr, ram_address, ram_data} !== 27'd0) begin
      errors++;
      $display("FAIL rs_clear got=%h exp=0",
               {checksum, max_value, max_addr, ram_address, ram_data});
    end
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen++;
      @(posedge clock);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rs_done got=%0d exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int nd, k1, k2, bad;
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'hF;
    load_ram();
    wait_idle();
    start = 1'b1;
    mode  = 1'b1;
    nd  = 0;
    k1  = 0;
    k2  = 0;
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        nd++;
        if (checksum !== 9'd480 || max_addr !== 5'd0 ||
            max_value !== 4'hF)
          bad++;
        if (nd == 1) k1 = k;
        else begin
          k2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (nd !== 2 || k1 !== 34 || k2 - k1 !== 35) begin
      errors++;
      $display("FAIL b2b_timing got=%0d,%0d,%0d exp=2,34,69", nd, k1, k2);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_result got=%0d exp=0 bad", bad);
    end
  endtask

  task automatic test_random();
    int lat, wr, bz;
    logic [8:0] s0;
    logic [3:0] m0;
    logic [4:0] a0;
    logic [3:0] f;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++)
        ref_mem[i] = (it % 2 == 0) ? 4'($urandom_range(0, 15))
                                   : 4'($urandom_range(0, 3)) + 4'hC;
      load_ram();
      run_op(1'b1, 4'($urandom), lat, wr, bz);
      check_scan("rnd", lat);
      s0 = checksum;
      m0 = max_value;
      a0 = max_addr;
      f  = 4'($urandom);
      run_op(1'b0, f, lat, wr, bz);
      for (int i = 0; i < 32; i++) ref_mem[i] = f;
      checks++;
      if ({checksum, max_value, max_addr} !== {s0, m0, a0}) begin
        errors++;
        $display("FAIL rnd_hold got=%h exp=%h",
                 {checksum, max_value, max_addr}, {s0, m0, a0});
      end
      checks++;
      if (lat !== 33 || mem_diffs() !== 0) begin
        errors++;
        $display("FAIL rnd_fill got=%0d/%0d exp=33/0", lat, mem_diffs());
      end
    end
  endtask

  initial begin
    clock     = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    fill_data = 4'h0;
    ld_en     = 1'b0;
    ld_addr   = 5'd0;
    ld_data   = 4'h0;
    errors    = 0;
    checks    = 0;
    repeat (3) @(posedge clock);
    test_reset();
    test_fill_scan();
    test_pattern();
    test_busy_start();
    test_reset_fill();
    test_reset_scan();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
